// File: rtl/axis_pkg.sv
// Shared encodings for the AXI-Stream decimator: averaging mode and log_rate port width.
package axis_pkg;

  localparam int LOG_RATE_W = 5;

  typedef enum logic {
    MODE_PICK    = 1'b0,
    MODE_AVERAGE = 1'b1
  } mode_e;

endpackage

// File: rtl/axis_decimator_lane.sv
// One sample lane of the decimator: boxcar accumulator plus floor-rounded mean.
module axis_decimator_lane
  import axis_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 16,
  parameter int MAX_LOG       = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     accept_i,
  input  logic                     first_i,
  input  logic [LOG_RATE_W-1:0]    shift_i,
  input  logic [CHANNEL_WIDTH-1:0] sample_i,
  output logic [CHANNEL_WIDTH-1:0] avg_o
);

  localparam int ACC_W = CHANNEL_WIDTH + MAX_LOG;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;

  assign sample_ext = {{MAX_LOG{sample_i[CHANNEL_WIDTH-1]}}, sample_i};

  // The first beat of a window adds to zero, which doubles as the accumulator load.
  always_comb begin
    sum   = (first_i ? '0 : acc_q) + sample_ext;
    acc_d = accept_i ? sum : acc_q;
    avg_o = CHANNEL_WIDTH'(sum >>> shift_i);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) acc_q <= '0;
    else          acc_q <= acc_d;
  end

endmodule

// File: rtl/axis_decimator.sv
// AXI-Stream decimator by 2^L: per-window pick-last or boxcar average, one output register stage.
module axis_decimator
  import axis_pkg::*;
#(
  parameter  int CHANNEL_WIDTH    = 16,
  parameter  int CHANNELS         = 2,
  parameter  int MAX_LOG          = 16,
  localparam int AXIS_TDATA_WIDTH = CHANNELS * CHANNEL_WIDTH
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [LOG_RATE_W-1:0]       log_rate,
  input  logic                        mode,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

  logic [MAX_LOG-1:0]          cnt_q, cnt_d;
  logic [LOG_RATE_W-1:0]       l_q, l_d;
  mode_e                       mode_q, mode_d;
  logic                        m_valid_q, m_valid_d;
  logic [AXIS_TDATA_WIDTH-1:0] m_data_q, m_data_d;

  logic [LOG_RATE_W-1:0]       l_in, cur_l;
  mode_e                       cur_mode;
  logic [MAX_LOG:0]            n_m1;
  logic                        first, win_end, accept;
  logic [AXIS_TDATA_WIDTH-1:0] avg_data;

  assign l_in = (log_rate > LOG_RATE_W'(MAX_LOG)) ? LOG_RATE_W'(MAX_LOG) : log_rate;

  // Settings are sampled on the first beat of a window, so that beat uses the live inputs.
  assign first    = (cnt_q == '0);
  assign cur_l    = first ? l_in : l_q;
  assign cur_mode = first ? mode_e'(mode) : mode_q;
  assign n_m1     = ((MAX_LOG + 1)'(1) << cur_l) - (MAX_LOG + 1)'(1);
  assign win_end  = ({1'b0, cnt_q} == n_m1);

  assign S_AXIS_tready = !m_valid_q || M_AXIS_tready;
  assign accept        = S_AXIS_tvalid && S_AXIS_tready;
  assign M_AXIS_tvalid = m_valid_q;
  assign M_AXIS_tdata  = m_data_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    axis_decimator_lane #(
      .CHANNEL_WIDTH (CHANNEL_WIDTH),
      .MAX_LOG       (MAX_LOG)
    ) u_lane (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .accept_i (accept),
      .first_i  (first),
      .shift_i  (cur_l),
      .sample_i (S_AXIS_tdata[k*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
      .avg_o    (avg_data[k*CHANNEL_WIDTH +: CHANNEL_WIDTH])
    );
  end

  always_comb begin
    cnt_d     = cnt_q;
    l_d       = l_q;
    mode_d    = mode_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;

    if (accept) begin
      if (first) begin
        l_d    = l_in;
        mode_d = cur_mode;
      end
      cnt_d = win_end ? '0 : cnt_q + MAX_LOG'(1);
    end

    // A new result takes priority over draining, which keeps tvalid high on back-to-back windows.
    if (accept && win_end) begin
      m_valid_d = 1'b1;
      m_data_d  = (cur_mode == MODE_AVERAGE) ? avg_data : S_AXIS_tdata;
    end else if (M_AXIS_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q     <= '0;
      l_q       <= '0;
      mode_q    <= MODE_PICK;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      l_q       <= l_d;
      mode_q    <= mode_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

endmodule

// File: tb/tb_axis_decimator.sv
// Self-checking bench for axis_decimator: window-level reference model plus directed literal checks.
module tb_axis_decimator;

  localparam int CW = 16;
  localparam int CH = 2;
  localparam int DW = CW * CH;
  localparam int ML = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [4:0]    log_rate = '0;
  logic          mode = 1'b0;
  logic          s_valid = 1'b0;
  logic          S_AXIS_tready;
  logic [DW-1:0] s_data = '0;
  logic          M_AXIS_tvalid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] M_AXIS_tdata;

  int checks = 0;
  int failures = 0;

  axis_decimator dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .log_rate      (log_rate),
    .mode          (mode),
    .S_AXIS_tvalid (s_valid),
    .S_AXIS_tready (S_AXIS_tready),
    .S_AXIS_tdata  (s_data),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tready (m_ready),
    .M_AXIS_tdata  (M_AXIS_tdata)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: gathers beats into windows and computes each result arithmetically.
  bit            mv = 1'b0;
  logic [DW-1:0] md = '0;
  bit            m_acc = 1'b0;
  int            win_cnt = 0;
  int            win_l = 0;
  bit            win_mode = 1'b0;
  longint        sums [CH];

  always @(posedge aclk) begin
    bit rdy;
    bit fire;
    logic [DW-1:0] nd;
    longint t;
    fire = 1'b0;
    nd   = '0;
    if (!aresetn) begin
      mv = 1'b0; md = '0; m_acc = 1'b0; win_cnt = 0; win_l = 0; win_mode = 1'b0;
      for (int k = 0; k < CH; k++) sums[k] = 0;
    end else begin
      rdy   = !mv || m_ready;
      m_acc = s_valid && rdy;
      if (m_acc) begin
        if (win_cnt == 0) begin
          win_l    = (int'(log_rate) > ML) ? ML : int'(log_rate);
          win_mode = mode;
          for (int k = 0; k < CH; k++) sums[k] = 0;
        end
        for (int k = 0; k < CH; k++) sums[k] += longint'($signed(s_data[k*CW +: CW]));
        win_cnt++;
        if (win_cnt == (1 << win_l)) begin
          fire    = 1'b1;
          win_cnt = 0;
          if (!win_mode) nd = s_data;
          else
            for (int k = 0; k < CH; k++) begin
              t = sums[k] >>> win_l;
              nd[k*CW +: CW] = t[CW-1:0];
            end
        end
      end
      if (fire) begin
        mv = 1'b1; md = nd;
      end else if (m_ready) mv = 1'b0;
    end
  end

  logic [DW-1:0] obs [$];

  always @(negedge aclk) begin
    check("tvalid", DW'(M_AXIS_tvalid), DW'(mv));
    check("tready", DW'(S_AXIS_tready), DW'(!mv || m_ready));
    check("tdata", M_AXIS_tdata, md);
    if (M_AXIS_tvalid && m_ready) obs.push_back(M_AXIS_tdata);
  end

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic beat(input logic [CW-1:0] l1, input logic [CW-1:0] l0);
    s_valid = 1'b1;
    s_data  = {l1, l0};
    tick();
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic expect_obs(input string name, input logic [DW-1:0] exp [$]);
    check({name, "_count"}, DW'(obs.size()), DW'(exp.size()));
    for (int i = 0; i < exp.size() && i < obs.size(); i++) check(name, obs[i], exp[i]);
    obs.delete();
  endtask

  initial begin
    int nxt;
    int nbeats;
    logic [DW-1:0] e [$];

    repeat (3) tick();
    check("reset_tready", DW'(S_AXIS_tready), DW'(1));
    check("reset_tvalid", DW'(M_AXIS_tvalid), DW'(0));
    aresetn = 1'b1;
    m_ready = 1'b1;

    // Pick, N=4, ramp 1..12.
    log_rate = 5'd2; mode = 1'b0;
    for (int i = 1; i <= 12; i++) beat(16'd0, CW'(i));
    idle(2);
    e = '{32'd4, 32'd8, 32'd12};
    expect_obs("pick4", e);

    // Average, N=4, floor rounding on negative lane.
    mode = 1'b1;
    beat(16'hFFFF, 16'd10);
    beat(16'hFFFE, 16'd20);
    beat(16'hFFFE, 16'd30);
    beat(16'hFFFE, 16'd41);
    idle(2);
    e = '{{16'hFFFE, 16'd25}};
    expect_obs("avg4", e);

    // Average, N=1, random valid: pass-through.
    log_rate = 5'd0;
    nbeats = 0;
    for (int i = 0; i < 200; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = DW'($urandom);
      if (s_valid) nbeats++;
      tick();
    end
    idle(2);
    check("pass_count", DW'(obs.size()), DW'(nbeats));
    obs.delete();

    // Pick, N=2, downstream stalled then released.
    log_rate = 5'd1; mode = 1'b0;
    nxt = 1;
    for (int c = 0; c < 30; c++) begin
      m_ready = (c >= 12);
      s_valid = (nxt <= 8);
      s_data  = DW'(nxt);
      if (c == 6) begin
        check("stall_tready", DW'(S_AXIS_tready), DW'(0));
        check("stall_tdata", M_AXIS_tdata, DW'(2));
      end
      tick();
      if (m_acc) nxt++;
    end
    m_ready = 1'b1;
    idle(2);
    e = '{32'd2, 32'd4, 32'd6, 32'd8};
    expect_obs("stall", e);

    // Rate change mid-window takes effect on the next window.
    log_rate = 5'd2;
    beat(16'd0, 16'd1);
    beat(16'd0, 16'd2);
    log_rate = 5'd1;
    for (int i = 3; i <= 8; i++) beat(16'd0, CW'(i));
    idle(2);
    e = '{32'd4, 32'd6, 32'd8};
    expect_obs("ratechg", e);

    // Reset mid-window discards the partial window.
    log_rate = 5'd2;
    beat(16'd0, 16'd1);
    beat(16'd0, 16'd2);
    beat(16'd0, 16'd3);
    s_valid = 1'b0;
    aresetn = 1'b0;
    tick();
    check("rst_tvalid", DW'(M_AXIS_tvalid), DW'(0));
    aresetn = 1'b1;
    for (int i = 100; i <= 103; i++) beat(16'd0, CW'(i));
    idle(2);
    e = '{32'd103};
    expect_obs("rstwin", e);

    // log_rate beyond MAX_LOG clamps to a 65536-beat window.
    log_rate = 5'd31;
    for (int i = 0; i < 65536; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(i);
      tick();
      if (i == 65534) check("big_none_yet", DW'(obs.size()), DW'(0));
    end
    idle(2);
    e = '{32'h0000FFFF};
    expect_obs("bigwin", e);

    // Random traffic, rates, modes and back-pressure against the model.
    for (int i = 0; i < 3000; i++) begin
      s_valid  = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 3) != 0);
      s_data   = DW'($urandom);
      if ($urandom_range(0, 15) == 0) log_rate = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) mode = 1'($urandom_range(0, 1));
      aresetn  = ($urandom_range(0, 499) != 0);
      tick();
    end
    aresetn = 1'b1;
    m_ready = 1'b1;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_decimator.md
AXIS_DECIMATOR -- requirements
Module: axis_decimator

Interface
REQ-001 SHALL have parameter CHANNEL_WIDTH, default 16: bit width of one signed sample lane.
REQ-002 SHALL have parameter CHANNELS, default 2: number of lanes packed in tdata, lane k at bits [k*CHANNEL_WIDTH +: CHANNEL_WIDTH].
REQ-003 SHALL have parameter MAX_LOG, default 16: largest supported log2 decimation factor.
REQ-004 SHALL derive AXIS_TDATA_WIDTH = CHANNELS*CHANNEL_WIDTH; it is not a free parameter.
REQ-005 aclk  input  1  clock; all logic on rising edge.
REQ-006 aresetn  input  1  reset, synchronous, active-low.
REQ-007 log_rate  input  5  log2 of decimation factor N = 2^log_rate.
REQ-008 mode  input  1  0 = PICK (keep last sample of window), 1 = AVERAGE (boxcar mean of window).
REQ-009 S_AXIS_tvalid  input  1;  S_AXIS_tready  output  1;  S_AXIS_tdata  input  AXIS_TDATA_WIDTH.
REQ-010 M_AXIS_tvalid  output  1;  M_AXIS_tready  input  1;  M_AXIS_tdata  output  AXIS_TDATA_WIDTH.

Function
REQ-011 SHALL count accepted input beats (S_AXIS_tvalid && S_AXIS_tready), not clock cycles; idle cycles do not advance the window.
REQ-012 SHALL use effective shift L = min(log_rate, MAX_LOG); N = 2^L.
REQ-013 SHALL latch L and mode on the first accepted beat of each window (beat counter == 0); changes mid-window take effect at the next window.
REQ-014 Beat counter SHALL be MAX_LOG bits, increment per accepted beat, wrap to 0 after the beat where counter == N-1 (window end).
REQ-015 PICK: on window end SHALL load the output register with that beat's tdata unchanged.
REQ-016 AVERAGE: per lane, SHALL sign-extend the sample into a CHANNEL_WIDTH+MAX_LOG accumulator; first beat of window loads, later beats add; no overflow possible.
REQ-017 AVERAGE: on window end SHALL output (accumulator + current sample) arithmetic-shifted right by L, truncated to CHANNEL_WIDTH (floor rounding; -1,-2 averages to -2).
REQ-018 N = 1 (L = 0) SHALL pass every beat through in both modes with one cycle latency.
REQ-019 Output SHALL be a single register stage: M_AXIS_tvalid rises the cycle after the window-end beat is accepted; M_AXIS_tdata holds stable while tvalid && !tready.
REQ-020 S_AXIS_tready SHALL equal !M_AXIS_tvalid || M_AXIS_tready (combinational), so no window result is ever dropped and back-pressure propagates.
REQ-021 Simultaneous output consumption and new window-end beat SHALL reload the output register in the same cycle, keeping tvalid high (full throughput at N = 1).
REQ-022 Non-window-end beats SHALL be accepted while the output register is full only if tready permits per REQ-020; no beat is accepted when S_AXIS_tready is low.
REQ-023 Throughput SHALL be one input beat per cycle when downstream is always ready.

Reset
REQ-024 While aresetn low: M_AXIS_tvalid = 0, M_AXIS_tdata = 0, beat counter = 0, accumulators = 0, latched L = 0, latched mode = PICK.
REQ-025 Reset mid-window SHALL discard partial window; first accepted beat after reset starts a new window.
REQ-026 S_AXIS_tready SHALL be 1 during and immediately after reset (output register empty).

Structure
REQ-027 Mode encodings (PICK, AVERAGE) and the log_rate port width constant SHALL live in shared package axis_pkg.
REQ-028 Per-lane accumulate/shift datapath SHALL be one sub-module axis_decimator_lane, instantiated CHANNELS times by generate; counter, latching and handshake stay in the top.

Verification
REQ-029 PICK, log_rate=2, ready=1, lane0 inputs 1,2,...,12 back-to-back -> outputs 4,8,12, each one cycle after beat 4/8/12.
REQ-030 AVERAGE, log_rate=2, lane0 inputs 10,20,30,41 and lane1 -1,-2,-2,-2 -> single output lane0=25, lane1=-2.
REQ-031 AVERAGE, log_rate=0, random tvalid, ready=1 -> output stream equals input stream, latency 1, no gaps beyond input gaps.
REQ-032 log_rate=1 PICK, M_AXIS_tready held 0 for 10 cycles after first output -> tdata stable, S_AXIS_tready low after next window-end candidate is pending, no output lost or duplicated on release.
REQ-033 log_rate changed 2->1 after beat 2 of a window -> current window still completes at 4 beats, next windows are 2 beats.
REQ-034 aresetn pulsed low after beat 3 of a log_rate=2 window -> no output for that window; next output after 4 further accepted beats; log_rate=31 with MAX_LOG=16 -> window of 65536 beats.
